// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM-to-stream burst reader.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO with fall-through when empty, so a word can leave
// in the same cycle it arrives.
module stream_fifo2
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W-1:0] DEPTH_C = FIFO_CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic [FIFO_CNT_W-1:0] count_d;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  store;
  logic                  unload;

  assign empty       = (count_q == '0);
  assign in_ready_o  = (count_q != DEPTH_C);
  assign out_valid_o = empty ? in_valid_i : 1'b1;
  assign count_o     = count_q;

  // Output is forced to zero when nothing is valid, which also keeps it clean in reset.
  always_comb begin
    out_data_o = '0;
    if (!empty) begin
      out_data_o = mem_q[rd_ptr_q];
    end else if (in_valid_i) begin
      out_data_o = in_data_i;
    end
  end

  assign push   = in_valid_i && in_ready_o;
  assign pop    = out_valid_o && out_ready_i;
  assign store  = push && !(empty && pop);
  assign unload = pop && !empty;

  always_comb begin
    count_d = count_q;
    if (store && !unload) begin
      count_d = count_q + 1'b1;
    end else if (!store && unload) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (store) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (unload) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from a BRAM and presents them as a valid/ready stream.
// Define BRAM_STREAM_STRIDE_EN to add a per-burst address stride input.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [RAM_ADDR_BITS-1:0]      base_addr,
  input  logic [RAM_ADDR_BITS:0]        length,
`ifdef BRAM_STREAM_STRIDE_EN
  input  logic [RAM_ADDR_BITS-1:0]      stride,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          ram_enable,
  output logic [RAM_ADDR_BITS-1:0]      ram_address,
  input  logic signed [RAM_WIDTH-1:0]   ram_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [RAM_WIDTH-1:0]   m_data,
  output logic                          m_last
);

  localparam logic [RAM_ADDR_BITS:0]  LEN_ZERO = '0;
  localparam logic [RAM_ADDR_BITS:0]  LEN_ONE  = (RAM_ADDR_BITS+1)'(1);
  localparam logic [FIFO_CNT_W-1:0]   DEPTH_C  = FIFO_CNT_W'(FIFO_DEPTH);

  state_e                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_ADDR_BITS-1:0] step_q;
  logic [RAM_ADDR_BITS-1:0] step_start;
  logic [RAM_ADDR_BITS:0]   remain_q;
  logic                     inflight_q;
  logic                     inflight_last_q;

  logic [FIFO_CNT_W-1:0]    fifo_count;
  logic [FIFO_CNT_W-1:0]    occupancy;
  logic                     fifo_in_ready;
  logic [RAM_WIDTH:0]       fifo_out;
  logic                     issue;
  logic                     issue_last;
  logic                     last_xfer;

`ifdef BRAM_STREAM_STRIDE_EN
  assign step_start = stride;
`else
  assign step_start = RAM_ADDR_BITS'(1);
`endif

  // Words buffered plus the one possibly in the BRAM output register must fit the FIFO.
  assign occupancy  = fifo_count + FIFO_CNT_W'(inflight_q);
  assign issue      = (state_q == READ) && (occupancy < DEPTH_C) && fifo_in_ready;
  assign issue_last = issue && (remain_q == LEN_ONE);
  assign last_xfer  = m_valid && m_ready && m_last;

  assign ram_enable  = issue;
  assign ram_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      step_q   <= '0;
      remain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            step_q   <= step_start;
            remain_q <= length;
            if (length == LEN_ZERO) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q   <= addr_q + step_q;
            remain_q <= remain_q - LEN_ONE;
            if (issue_last) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // BRAM output is valid the cycle after ram_enable; track it with its last flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
    end
  end

  stream_fifo2 #(
    .WIDTH(RAM_WIDTH + 1)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .in_valid_i (inflight_q),
    .in_ready_o (fifo_in_ready),
    .in_data_i  ({inflight_last_q, ram_data}),
    .out_valid_o(m_valid),
    .out_ready_i(m_ready),
    .out_data_o (fifo_out),
    .count_o    (fifo_count)
  );

  assign m_data = fifo_out[RAM_WIDTH-1:0];
  assign m_last = fifo_out[RAM_WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM and a stream monitor.
module tb_bram_stream_reader;

  localparam int W = 32;
  localparam int A = 9;

  logic                clock     = 1'b0;
  logic                reset_n   = 1'b0;
  logic                start     = 1'b0;
  logic [A-1:0]        base_addr = '0;
  logic [A:0]          length    = '0;
`ifdef BRAM_STREAM_STRIDE_EN
  logic [A-1:0]        stride    = 9'd1;
`endif
  logic                busy;
  logic                done;
  logic                ram_enable;
  logic [A-1:0]        ram_address;
  logic signed [W-1:0] ram_data  = 32'sh1234_5678;
  logic                m_valid;
  logic                m_ready   = 1'b1;
  logic signed [W-1:0] m_data;
  logic                m_last;

  always #5 clock = ~clock;

  bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
`ifdef BRAM_STREAM_STRIDE_EN
    .stride     (stride),
`endif
    .busy       (busy),
    .done       (done),
    .ram_enable (ram_enable),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  function automatic logic [31:0] word(input logic [A-1:0] a);
    return {16'hC35A, 7'd0, a};
  endfunction

  always @(posedge clock) begin
    if (ram_enable) ram_data <= word(ram_address);
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stream monitor, sampled on the falling edge.
  logic         mon_clr     = 1'b0;
  int           rd_n        = 0;
  int           xf_n        = 0;
  int           occ_bad     = 0;
  int           stab_bad    = 0;
  int           first_valid = -1;
  int           last_xfer_c = -1;
  int           done_n      = 0;
  int           done_c      = -1;
  int           valid_n     = 0;
  logic [A-1:0] aq[$];
  logic [31:0]  dq[$];
  logic         lq[$];
  logic         hold_prev   = 1'b0;
  logic [31:0]  prev_data   = '0;
  logic         prev_last   = 1'b0;

  always @(negedge clock) begin
    if (mon_clr) begin
      rd_n = 0; xf_n = 0; occ_bad = 0; stab_bad = 0; first_valid = -1;
      last_xfer_c = -1; done_n = 0; done_c = -1; valid_n = 0;
      aq.delete(); dq.delete(); lq.delete(); hold_prev = 1'b0;
    end else if (reset_n) begin
      if (ram_enable) begin
        if (rd_n - xf_n >= 2) occ_bad++;
        aq.push_back(ram_address);
        rd_n++;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid) valid_n++;
      if (hold_prev && (!m_valid || $unsigned(m_data) !== prev_data || m_last !== prev_last))
        stab_bad++;
      hold_prev = m_valid && !m_ready;
      prev_data = $unsigned(m_data);
      prev_last = m_last;
      if (m_valid && m_ready) begin
        dq.push_back($unsigned(m_data));
        lq.push_back(m_last);
        xf_n++;
        last_xfer_c = cyc;
      end
      if (done) begin
        done_n++;
        done_c = cyc;
      end
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clock);
    #1 mon_clr = 1'b0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_ren"}, ram_enable, 0);
    chk({pfx, "_mvalid"}, m_valid, 0);
    chk({pfx, "_mlast"}, m_last, 0);
    chk({pfx, "_addr"}, ram_address, 0);
    chk({pfx, "_mdata"}, $unsigned(m_data), 0);
  endtask

  // stall: m_ready follows 1,0,0,1 from the start cycle; poke: extra start mid-burst.
  task automatic burst(input logic [A-1:0] base, input logic [A:0] len,
                       input bit stall, input bit poke, output int s_cyc);
    clear_mon();
    @(posedge clock); #1;
    start = 1'b1; base_addr = base; length = len; m_ready = 1'b1;
    s_cyc = cyc;
    for (int i = 1; i < 300; i++) begin
      @(posedge clock); #1;
      start = poke && (i == 3);
      if (poke && i == 3) begin
        base_addr = 9'd300;
        length    = 10'd2;
      end
      m_ready = stall ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      if (done_n > 0) break;
    end
    chk("done_seen", done_n > 0, 1);
    start = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic chk_stream(input logic [A-1:0] base, input int len, input logic [A-1:0] step);
    logic [A-1:0] a;
    a = base;
    chk("n_words", xf_n, len);
    chk("n_reads", rd_n, len);
    for (int i = 0; i < len; i++) begin
      if (i < dq.size()) begin
        chk($sformatf("data%0d", i), dq[i], word(a));
        chk($sformatf("last%0d", i), lq[i], (i == len - 1));
      end
      if (i < aq.size()) chk($sformatf("addr%0d", i), aq[i], a);
      a = a + step;
    end
    chk("occupancy", occ_bad, 0);
    chk("stable", stab_bad, 0);
    chk("done_pulses", done_n, 1);
  endtask

  initial begin
    int s;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outs("rst");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("idle_busy", busy, 0);

    // Straight burst at full rate
    burst(9'd0, 10'd4, 1'b0, 1'b0, s);
    chk_stream(9'd0, 4, 9'd1);
    chk("first_valid_lat", first_valid - s, 2);
    chk("back_to_back", last_xfer_c - first_valid, 3);
    chk("done_after_last", done_c - last_xfer_c, 1);
    chk("busy_after", busy, 0);

    // Address wrap
    burst(9'd510, 10'd4, 1'b0, 1'b0, s);
    chk_stream(9'd510, 4, 9'd1);
    if (aq.size() == 4) begin
      chk("wrap_a0", aq[0], 510);
      chk("wrap_a1", aq[1], 511);
      chk("wrap_a2", aq[2], 0);
      chk("wrap_a3", aq[3], 1);
    end else begin
      chk("wrap_nreads", aq.size(), 4);
    end

    // Backpressure 1,0,0,1 plus an ignored start mid-burst
    burst(9'd20, 10'd8, 1'b1, 1'b1, s);
    chk_stream(9'd20, 8, 9'd1);

    // Zero length
    burst(9'd5, 10'd0, 1'b0, 1'b0, s);
    chk("zero_done_lat", done_c - s, 1);
    chk("zero_reads", rd_n, 0);
    chk("zero_valid", valid_n, 0);
    chk("zero_done_n", done_n, 1);

    // Reset at the third word of a 6-word burst
    clear_mon();
    @(posedge clock); #1;
    start = 1'b1; base_addr = 9'd40; length = 10'd6; m_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_valid", m_valid, 1);
    chk("mid_data", $unsigned(m_data), word(9'd42));
    reset_n = 1'b0;
    #1;
    chk_reset_outs("abort");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    burst(9'd100, 10'd2, 1'b0, 1'b0, s);
    chk_stream(9'd100, 2, 9'd1);

`ifdef BRAM_STREAM_STRIDE_EN
    stride = 9'd3;
    burst(9'd0, 10'd3, 1'b0, 1'b0, s);
    chk_stream(9'd0, 3, 9'd3);
    if (aq.size() == 3) begin
      chk("stride_a1", aq[1], 3);
      chk("stride_a2", aq[2], 6);
    end else begin
      chk("stride_nreads", aq.size(), 3);
    end
    stride = 9'd1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
